// File: rtl/npc_pc_unit.sv
// Fetch-stage program counter: selects the next fetch address from exception
// entry, eret return, stall hold, resolved branch/jump targets, or PC+4.
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_d,
  input  logic        beq_d,
  input  logic        bne_d,
  input  logic        j_d,
  input  logic        jr_d,
  input  logic        zero,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_fwd_d,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic        adel_f,
  output logic        bd_f
);

  logic [31:0] fetch_pc_d, fetch_pc_q;
  logic        bd_d, bd_q;
  logic [31:0] seq_pc_s, br_target_s, j_target_s;
  logic        br_taken_s, is_cti_s;

  // Next-PC selection; req and eret win over a stall so faults are never held off.
  always_comb begin
    seq_pc_s    = fetch_pc_q + 32'd4;
    br_target_s = pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    j_target_s  = {pc_d[31:28], index26_d, 2'b00};
    br_taken_s  = (beq_d & zero) | (bne_d & ~zero);
    is_cti_s    = beq_d | bne_d | j_d | jr_d;
    fetch_pc_d  = fetch_pc_q;
    bd_d        = bd_q;
    if (req) begin
      fetch_pc_d = HANDLER_PC;
      bd_d       = 1'b0;
    end else if (eret) begin
      fetch_pc_d = epc;
      bd_d       = 1'b0;
    end else if (stall) begin
      fetch_pc_d = fetch_pc_q;
      bd_d       = bd_q;
    end else begin
      // The slot flag tracks the control instruction itself, taken or not.
      bd_d = is_cti_s;
      if (jr_d) begin
        fetch_pc_d = rs_fwd_d;
      end else if (j_d) begin
        fetch_pc_d = j_target_s;
      end else if (br_taken_s) begin
        fetch_pc_d = br_target_s;
      end else begin
        fetch_pc_d = seq_pc_s;
      end
    end
  end

  // PC and delay-slot state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      bd_q       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      bd_q       <= bd_d;
    end
  end

  assign pc_f   = fetch_pc_q;
  assign bd_f   = bd_q;
  // Misaligned or outside instruction memory; a bad jr target is flagged, not fixed.
  assign adel_f = (fetch_pc_q[1:0] != 2'b00) | (fetch_pc_q < IM_LO) | (fetch_pc_q > IM_HI);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Bench for npc_pc_unit: directed scenarios plus randomized traffic checked
// against a behavioural next-PC model.
module tb_npc_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall, beq_d, bne_d, j_d, jr_d, zero, req, eret;
  logic [31:0] pc_d, rs_fwd_d, epc;
  logic [15:0] imm16_d;
  logic [25:0] index26_d;
  logic [31:0] pc_f;
  logic        adel_f, bd_f;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic        m_bd;

  npc_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_d(pc_d),
    .beq_d(beq_d), .bne_d(bne_d), .j_d(j_d), .jr_d(jr_d), .zero(zero),
    .imm16_d(imm16_d), .index26_d(index26_d), .rs_fwd_d(rs_fwd_d),
    .req(req), .eret(eret), .epc(epc),
    .pc_f(pc_f), .adel_f(adel_f), .bd_f(bd_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic model_adel(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || (a < IM_LO) || (a > IM_HI);
  endfunction

  // One clock edge of the reference: apply the priority rules in plain arithmetic.
  task automatic model_edge();
    int          off;
    logic [31:0] br_tgt, j_tgt;
    logic        taken;
    off    = int'($signed(imm16_d));
    br_tgt = pc_d + 32'd4 + 32'(off * 4);
    j_tgt  = (pc_d & 32'hF000_0000) + ({6'd0, index26_d} * 32'd4);
    taken  = (beq_d && zero) || (bne_d && !zero);
    if (req) begin
      m_pc = HANDLER_PC; m_bd = 1'b0;
    end else if (eret) begin
      m_pc = epc; m_bd = 1'b0;
    end else if (!stall) begin
      m_bd = beq_d || bne_d || j_d || jr_d;
      if (jr_d)       m_pc = rs_fwd_d;
      else if (j_d)   m_pc = j_tgt;
      else if (taken) m_pc = br_tgt;
      else            m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    stall = 1'b0; beq_d = 1'b0; bne_d = 1'b0; j_d = 1'b0; jr_d = 1'b0;
    zero = 1'b0; req = 1'b0; eret = 1'b0; pc_d = RESET_PC;
    rs_fwd_d = RESET_PC; epc = RESET_PC; imm16_d = 16'd0; index26_d = 26'd0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, ".pc"}, pc_f, m_pc);
    chk({tag, ".bd"}, {31'd0, bd_f}, {31'd0, m_bd});
    chk({tag, ".adel"}, {31'd0, adel_f}, {31'd0, model_adel(m_pc)});
  endtask

  initial begin
    idle();
    #2 reset = 1'b1;
    #1;
    chk("rst.pc", pc_f, 32'h0000_3000);
    chk("rst.bd", {31'd0, bd_f}, 32'd0);
    chk("rst.adel", {31'd0, adel_f}, 32'd0);
    m_pc = RESET_PC; m_bd = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Three idle edges.
    step("idle1"); chk("idle1.lit", pc_f, 32'h0000_3004);
    step("idle2"); chk("idle2.lit", pc_f, 32'h0000_3008);
    step("idle3"); chk("idle3.lit", pc_f, 32'h0000_300C);

    // Backward beq taken, then not taken.
    pc_d = 32'h0000_3010; beq_d = 1'b1; zero = 1'b1; imm16_d = 16'hFFFE;
    step("beq_t"); chk("beq_t.lit", pc_f, 32'h0000_300C); chk("beq_t.bdlit", {31'd0, bd_f}, 32'd1);
    zero = 1'b0;
    step("beq_nt"); chk("beq_nt.lit", pc_f, 32'h0000_3010); chk("beq_nt.bdlit", {31'd0, bd_f}, 32'd1);
    idle();
    step("idle4"); chk("idle4.lit", pc_f, 32'h0000_3014);

    // bne held under stall for two edges, taken on release.
    pc_d = 32'h0000_3014; bne_d = 1'b1; zero = 1'b0; imm16_d = 16'h0004; stall = 1'b1;
    step("stall1"); chk("stall1.lit", pc_f, 32'h0000_3014);
    step("stall2"); chk("stall2.lit", pc_f, 32'h0000_3014);
    stall = 1'b0;
    step("bne_rel"); chk("bne_rel.lit", pc_f, 32'h0000_3028);

    // req beats stall and j; then eret returns.
    idle(); req = 1'b1; stall = 1'b1; j_d = 1'b1; index26_d = 26'h0000_C40;
    step("req"); chk("req.lit", pc_f, 32'h0000_4180); chk("req.bdlit", {31'd0, bd_f}, 32'd0);
    idle(); eret = 1'b1; epc = 32'h0000_3020;
    step("eret"); chk("eret.lit", pc_f, 32'h0000_3020); chk("eret.bdlit", {31'd0, bd_f}, 32'd0);

    // jr targets at and beyond the legal boundaries.
    idle(); jr_d = 1'b1; rs_fwd_d = 32'h0000_3002;
    step("jr_mis"); chk("jr_mis.lit", pc_f, 32'h0000_3002); chk("jr_mis.adel", {31'd0, adel_f}, 32'd1);
    rs_fwd_d = 32'h0000_7000;
    step("jr_hi"); chk("jr_hi.adel", {31'd0, adel_f}, 32'd1);
    rs_fwd_d = 32'h0000_6FFC;
    step("jr_top"); chk("jr_top.adel", {31'd0, adel_f}, 32'd0);
    rs_fwd_d = 32'h0000_2FFC;
    step("jr_lo"); chk("jr_lo.adel", {31'd0, adel_f}, 32'd1);

    // Jump to 3040, then asynchronous reset between edges with a jump pending.
    idle(); j_d = 1'b1; pc_d = 32'h0000_3000; index26_d = 26'h0000_C10;
    step("j3040"); chk("j3040.lit", pc_f, 32'h0000_3040);
    #2 reset = 1'b1;
    #1;
    chk("arst.pc", pc_f, 32'h0000_3000);
    chk("arst.bd", {31'd0, bd_f}, 32'd0);
    m_pc = RESET_PC; m_bd = 1'b0;
    #1 reset = 1'b0;
    idle();
    step("post_rst"); chk("post_rst.lit", pc_f, 32'h0000_3004);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      req       = ($urandom_range(0, 19) == 0);
      eret      = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      beq_d     = ($urandom_range(0, 3) == 0);
      bne_d     = ($urandom_range(0, 3) == 0);
      j_d       = ($urandom_range(0, 5) == 0);
      jr_d      = ($urandom_range(0, 5) == 0);
      zero      = 1'($urandom_range(0, 1));
      imm16_d   = 16'($urandom);
      pc_d      = {18'd0, 14'($urandom_range(32'h0C00, 32'h1BFF)), 2'b00} & 32'h0000_7FFC;
      index26_d = 26'($urandom_range(32'h0C00, 32'h1BFF));
      rs_fwd_d  = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : {16'd0, 16'($urandom_range(32'h3000, 32'h6FFF))};
      epc       = {16'd0, 14'($urandom_range(32'h0C00, 32'h1BFF)), 2'b00};
      step($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
NPC_PC_UNIT -- requirements
Module: npc_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, fetch address loaded on reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, exception/interrupt entry address.
REQ-003 Parameter IM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-004 Parameter IM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hazard stall from the D stage; hold the F-stage PC.
REQ-008 pc_d  in  32  PC of the instruction currently in D.
REQ-009 beq_d, bne_d  in  1 each  D-stage instruction is beq / bne.
REQ-010 j_d  in  1  D-stage instruction is j or jal.
REQ-011 jr_d  in  1  D-stage instruction is jr or jalr.
REQ-012 zero  in  1  equality result from the D-stage comparator (1 = operands equal).
REQ-013 imm16_d  in  16  branch offset field.
REQ-014 index26_d  in  26  jump index field.
REQ-015 rs_fwd_d  in  32  forwarded rs value for jr/jalr.
REQ-016 req  in  1  exception/interrupt request from CP0.
REQ-017 eret  in  1  eret in D stage.
REQ-018 epc  in  32  return address from CP0.
REQ-019 pc_f  out  32  current fetch address (registered).
REQ-020 adel_f  out  1  fetch address misaligned or out of range (combinational on pc_f).
REQ-021 bd_f  out  1  instruction at pc_f is in a branch delay slot (registered).

Function
REQ-022 Next-PC priority, highest first, SHALL be: req, eret, stall, taken control transfer, sequential.
REQ-023 req=1: pc_f <= HANDLER_PC next edge, regardless of stall; bd_f <= 0.
REQ-024 eret=1 and req=0: pc_f <= epc next edge, regardless of stall; bd_f <= 0 (no delay slot for eret).
REQ-025 stall=1, req=0, eret=0: pc_f and bd_f hold their values.
REQ-026 Branch target = pc_d + 4 + (sign-extended imm16_d << 2), 32-bit wrap-around, carry discarded.
REQ-027 Branch taken SHALL be beq_d&zero | bne_d&~zero.
REQ-028 Jump target = {pc_d[31:28], index26_d, 2'b00}; jr target = rs_fwd_d unmodified.
REQ-029 If more than one of {branch taken, j_d, jr_d} is asserted, priority is jr_d, then j_d, then branch.
REQ-030 No transfer taken and no stall: pc_f <= pc_f + 4, 32-bit wrap-around.
REQ-031 Branch resolution latency: zero is sampled in the same cycle the branch is in D; the target appears on pc_f one edge later, and the delay-slot instruction is already in F.
REQ-032 bd_f <= (beq_d | bne_d | j_d | jr_d) on every non-stalled, non-req, non-eret edge, independent of whether the branch is taken.
REQ-033 adel_f = (pc_f[1:0] != 0) | (pc_f < IM_LO) | (pc_f > IM_HI), unsigned comparison.
REQ-034 A misaligned jr target SHALL be loaded into pc_f unchanged; adel_f flags it and req handles the fault.
REQ-035 Control inputs are don't-care when stall=1, except req and eret.

Reset
REQ-036 reset=1 SHALL immediately set pc_f=RESET_PC and bd_f=0, asynchronously; adel_f=0 follows.
REQ-037 Reset mid-operation overrides all inputs; a pending branch is discarded, and the first post-reset edge yields RESET_PC+4.

Verification
REQ-038 Reset, then 3 idle edges -> pc_f 3000, 3004, 3008, 300C; bd_f=0; adel_f=0.
REQ-039 pc_d=3010, beq_d=1, zero=1, imm16_d=FFFE -> next pc_f=300C, bd_f=1; same with zero=0 -> pc_f=pc_f+4, bd_f=1.
REQ-040 stall=1 for 2 cycles with bne_d=1, zero=0 -> pc_f held; after release, the target is taken on the first free edge.
REQ-041 req=1 together with stall=1 and j_d=1 -> pc_f=4180, bd_f=0; then eret=1, epc=3020 -> pc_f=3020, bd_f=0.
REQ-042 jr_d=1, rs_fwd_d=3002 -> pc_f=3002, adel_f=1; rs_fwd_d=7000 -> adel_f=1; rs_fwd_d=6FFC -> adel_f=0.
REQ-043 Assert reset asynchronously between edges while pc_f=3040 -> pc_f=3000 before the next edge.
